pipeline_icache: RTL and testbench

//  Read-only, direct-mapped instruction cache between the pipeline fetch port
//  (inst_read/inst_addr -> inst_rdata/inst_resp) and the 256-bit line memory.
//  A hit returns the addressed word in the same cycle. A miss refills one
//  32-byte line from physical memory, then serves the request.
//  Hit and miss counters are kept for performance analysis.

---
 rtl/pipeline_icache.sv | 124 ++++++++++++
 tb/tb_pipeline_icache.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_icache.sv
// pipeline_icache: read-only direct-mapped instruction cache.
// Same-cycle hit path from flop arrays; a miss refills one 32-byte line from
// memory through a two-state controller, then the request is served as a hit.
module pipeline_icache #(
   parameter int unsigned NUM_SETS = 16,
   parameter int unsigned CNT_W    = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_read,
   input  logic [31:0]       inst_addr,
   output logic [31:0]       inst_rdata,
   output logic              inst_resp,
   output logic              pmem_read,
   output logic [31:0]       pmem_address,
   input  logic [255:0]      pmem_rdata,
   input  logic              pmem_resp,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count
);

   localparam int unsigned IDX_W = $clog2(NUM_SETS);
   localparam int unsigned TAG_W = 27 - IDX_W;

   typedef enum logic {IDLE, FETCH} state_t;

   state_t              state_q, state_d;
   logic [NUM_SETS-1:0] valid_q, valid_d;
   logic [26:0]         line_q, line_d;
   logic [CNT_W-1:0]    hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0]    miss_cnt_q, miss_cnt_d;

   logic [TAG_W-1:0]    tag_q  [NUM_SETS];
   logic [255:0]        data_q [NUM_SETS];

   logic [IDX_W-1:0]    req_idx;
   logic [TAG_W-1:0]    req_tag;
   logic [7:0]          word_lsb;
   logic [255:0]        req_line;
   logic [IDX_W-1:0]    fill_idx;
   logic [TAG_W-1:0]    fill_tag;
   logic                hit;
   logic                fill_done;
   logic                addr_unused;

   assign req_idx     = inst_addr[5 +: IDX_W];
   assign req_tag     = inst_addr[31 -: TAG_W];
   assign word_lsb    = {inst_addr[4:2], 5'b0};
   assign req_line    = data_q[req_idx];
   assign fill_idx    = line_q[IDX_W-1:0];
   assign fill_tag    = line_q[26 -: TAG_W];
   assign fill_done   = (state_q == FETCH) && pmem_resp;
   assign addr_unused = ^inst_addr[1:0];

   // Hit detection and CPU-facing outputs; reset masks a stale hit.
   always_comb begin
      hit        = !reset && (state_q == IDLE) && inst_read &&
                   valid_q[req_idx] && (tag_q[req_idx] == req_tag);
      inst_resp  = hit;
      inst_rdata = hit ? req_line[word_lsb +: 32] : '0;
   end

   // Memory-facing outputs, decoded only from registered state.
   always_comb begin
      pmem_read    = (state_q == FETCH);
      pmem_address = (state_q == FETCH) ? {line_q, 5'b0} : '0;
   end

   // Next-state logic for the controller, valid bits and saturating counters.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      line_d     = line_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      case (state_q)
         IDLE: begin
            if (hit) begin
               if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
            end else if (inst_read) begin
               state_d = FETCH;
               line_d  = inst_addr[31:5];
               if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
            end
         end
         FETCH: begin
            if (pmem_resp) begin
               valid_d[fill_idx] = 1'b1;
               state_d           = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Controller state, valid bits and counters with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         valid_q    <= '0;
         line_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         line_q     <= line_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   // Tag and data arrays; unreset, qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (fill_done && !reset) begin
         tag_q[fill_idx]  <= fill_tag;
         data_q[fill_idx] <= pmem_rdata;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_pipeline_icache.sv
// tb_pipeline_icache: directed table, corner-case sequences and randomized
// fetches checked against a line-level reference model of the cache.
module tb_pipeline_icache;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              inst_read;
   logic [31:0]       inst_addr;
   logic [31:0]       inst_rdata;
   logic              inst_resp;
   logic              pmem_read;
   logic [31:0]       pmem_address;
   logic [255:0]      pmem_rdata;
   logic              pmem_resp;
   logic [CNT_W-1:0]  hit_count;
   logic [CNT_W-1:0]  miss_count;

   pipeline_icache #(.NUM_SETS(16), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .inst_read(inst_read), .inst_addr(inst_addr),
      .inst_rdata(inst_rdata), .inst_resp(inst_resp),
      .pmem_read(pmem_read), .pmem_address(pmem_address),
      .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .hit_count(hit_count), .miss_count(miss_count)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // Reference model: which memory line each set holds, plus counts.
   bit          m_valid [16];
   logic [31:0] m_line  [16];
   int          m_hits;
   int          m_misses;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] memword(input logic [31:0] a);
      logic [31:0] line;
      logic [31:0] w;
      line = {a[31:5], 5'b0};
      w    = {29'b0, a[4:2]};
      if (line == 32'h60)       return 32'hA0 + w;
      else if (line == 32'h260) return 32'hB0 + w;
      else                      return (line * 32'h9E37_79B9) ^ (w << 24) ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [255:0] mkline(input logic [31:0] line);
      logic [255:0] l;
      for (int w = 0; w < 8; w++) l[32*w +: 32] = memword(line + 32'(4 * w));
      return l;
   endfunction

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic bit m_hit(input logic [31:0] a);
      int idx;
      idx = int'(a[8:5]);
      return m_valid[idx] && (m_line[idx] == {a[31:5], 5'b0});
   endfunction

   function automatic logic [255:0] garbage();
      logic [255:0] g;
      for (int w = 0; w < 8; w++) g[32*w +: 32] = $urandom;
      return g;
   endfunction

   task automatic m_clear();
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
      m_hits   = 0;
      m_misses = 0;
   endtask

   task automatic chk_counts(input string nm);
      chk({nm, "_hits"},   32'(hit_count),  32'(m_hits));
      chk({nm, "_misses"}, 32'(miss_count), 32'(m_misses));
   endtask

   // One fetch: lookup, optional refill (with drop / address change), re-lookup.
   task automatic txn(input logic [31:0] a0, input int lat, input bit drop,
                      input bit chg, input logic [31:0] a1,
                      output bit resp, output logic [31:0] data);
      logic [31:0] a;
      logic [31:0] line;
      bit          c;
      a = a0; c = chg; resp = 1'b0; data = '0;
      for (int it = 0; it < 3; it++) begin
         inst_read = 1'b1;
         inst_addr = a;
         @(negedge clk);
         if (m_hit(a)) begin
            chk("hit_resp", 32'(inst_resp), 32'd1);
            chk("hit_data", inst_rdata, memword(a));
            chk("hit_pmem_read", 32'(pmem_read), 32'd0);
            m_hits = sat(m_hits + 1);
            resp = 1'b1;
            data = inst_rdata;
            @(posedge clk); #1;
            return;
         end
         chk("miss_resp", 32'(inst_resp), 32'd0);
         chk("miss_rdata", inst_rdata, 32'd0);
         m_misses = sat(m_misses + 1);
         @(posedge clk); #1;
         line = {a[31:5], 5'b0};
         for (int k = 0; k <= lat; k++) begin
            if (k == lat) begin
               pmem_resp  = 1'b1;
               pmem_rdata = mkline(line);
            end
            if (k == 0 && drop) inst_read = 1'b0;
            if (k == 0 && c)    inst_addr = a1;
            @(negedge clk);
            chk("fetch_pmem_read", 32'(pmem_read), 32'd1);
            chk("fetch_pmem_addr", pmem_address, line);
            chk("fetch_no_resp", 32'(inst_resp), 32'd0);
            @(posedge clk); #1;
         end
         pmem_resp  = 1'b0;
         pmem_rdata = garbage();
         m_valid[int'(line[8:5])] = 1'b1;
         m_line[int'(line[8:5])]  = line;
         if (drop) begin
            @(negedge clk);
            chk("drop_no_resp", 32'(inst_resp), 32'd0);
            chk("drop_pmem_read", 32'(pmem_read), 32'd0);
            @(posedge clk); #1;
            return;
         end
         if (c) begin
            a = a1;
            c = 1'b0;
         end
      end
      chk("txn_bound", 32'd0, 32'd1);
   endtask

   // Idle cycle, optionally with a stray memory response that must be ignored.
   task automatic idle(input bit stray);
      inst_read  = 1'b0;
      inst_addr  = $urandom;
      pmem_resp  = stray;
      pmem_rdata = garbage();
      @(negedge clk);
      chk("idle_resp", 32'(inst_resp), 32'd0);
      chk("idle_rdata", inst_rdata, 32'd0);
      chk("idle_pmem_read", 32'(pmem_read), 32'd0);
      chk("idle_pmem_addr", pmem_address, 32'd0);
      @(posedge clk); #1;
      pmem_resp = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      inst_read = 1'b0;
      pmem_resp = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_clear();
   endtask

   typedef struct {
      logic [31:0] addr;
      int          lat;
      bit          drop;
      bit          exp_resp;
      logic [31:0] exp_data;
      int          exp_hits;
      int          exp_misses;
   } vec_t;

   vec_t tbl [7];

   initial begin
      bit          r;
      logic [31:0] d;

      tbl[0] = '{32'h0000_0060, 2, 1'b0, 1'b1, 32'hA0, 1, 1};
      tbl[1] = '{32'h0000_0064, 0, 1'b0, 1'b1, 32'hA1, 2, 1};
      tbl[2] = '{32'h0000_007C, 0, 1'b0, 1'b1, 32'hA7, 3, 1};
      tbl[3] = '{32'h0000_0260, 1, 1'b0, 1'b1, 32'hB0, 4, 2};
      tbl[4] = '{32'h0000_0060, 0, 1'b0, 1'b1, 32'hA0, 5, 3};
      tbl[5] = '{32'h0000_0100, 2, 1'b1, 1'b0, 32'h0,  5, 4};
      tbl[6] = '{32'h0000_0104, 0, 1'b0, 1'b1, memword(32'h104), 6, 4};

      reset      = 1'b1;
      inst_read  = 1'b0;
      inst_addr  = '0;
      pmem_resp  = 1'b0;
      pmem_rdata = '0;
      m_clear();
      @(posedge clk); @(posedge clk); #1;
      reset = 1'b0;

      @(negedge clk);
      chk("rst_resp", 32'(inst_resp), 32'd0);
      chk("rst_rdata", inst_rdata, 32'd0);
      chk("rst_pmem_read", 32'(pmem_read), 32'd0);
      chk("rst_pmem_addr", pmem_address, 32'd0);
      chk_counts("rst");
      @(posedge clk); #1;

      // Directed table: first fill, same-line hits, conflict eviction, drop.
      for (int i = 0; i < 7; i++) begin
         txn(tbl[i].addr, tbl[i].lat, tbl[i].drop, 1'b0, '0, r, d);
         chk("tbl_resp", 32'(r), 32'(tbl[i].exp_resp));
         chk("tbl_data", d, tbl[i].exp_data);
         chk("tbl_hits", 32'(hit_count), 32'(tbl[i].exp_hits));
         chk("tbl_misses", 32'(miss_count), 32'(tbl[i].exp_misses));
      end

      // Reset while refilling 0x200: refill abandoned, counters cleared.
      inst_read = 1'b1;
      inst_addr = 32'h200;
      @(negedge clk);
      chk("r5_miss", 32'(inst_resp), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("r5_fetch", 32'(pmem_read), 32'd1);
      chk("r5_addr", pmem_address, 32'h200);
      reset     = 1'b1;
      inst_read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      m_clear();
      @(negedge clk);
      chk("r5_pmem_read", 32'(pmem_read), 32'd0);
      chk("r5_pmem_addr", pmem_address, 32'd0);
      chk_counts("r5");
      @(posedge clk); #1;
      txn(32'h200, 1, 1'b0, 1'b0, '0, r, d);
      chk("r5_refetch_misses", 32'(miss_count), 32'd1);

      // Hit counter saturation at all-ones.
      for (int i = 0; i < 20; i++) txn(32'h204, 0, 1'b0, 1'b0, '0, r, d);
      chk("sat_hits", 32'(hit_count), 32'hF);

      // Address changed while refilling: latched line filled, new one looked up.
      txn(32'h0000_0300, 1, 1'b0, 1'b1, 32'h0000_0540, r, d);
      chk("chg_resp", 32'(r), 32'd1);
      chk("chg_data", d, memword(32'h540));

      // Randomized fetches against the reference model.
      do_reset();
      for (int i = 0; i < 160; i++) begin
         logic [31:0] a, a1;
         bit          drop, chg;
         if (i == 80) do_reset();
         a    = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) |
                ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         a1   = ($urandom_range(0, 3) << 9) | ($urandom_range(0, 15) << 5) |
                ($urandom_range(0, 7) << 2);
         drop = ($urandom_range(0, 7) == 0);
         chg  = !drop && ($urandom_range(0, 7) == 0);
         txn(a, $urandom_range(0, 3), drop, chg, a1, r, d);
         chk_counts("rnd");
         if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 1) == 1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
